// File: rtl/example_data_memory_arbiter_pkg.sv
// Shared types for the two-master data memory arbiter (package rv_arbiter).
package rv_arbiter;

  localparam int unsigned MASTER_COUNT = 2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_t;

endpackage

// File: rtl/example_arb_picker.sv
// Combinational winner select; on a tie the requester not granted last time wins.
module example_arb_picker
  import rv_arbiter::*;
(
  input  logic [MASTER_COUNT-1:0] req_valid,
  input  logic                    last_grant,
  output logic                    grant_valid,
  output logic                    grant_id
);

  always_comb begin
    grant_valid = |req_valid;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/example_data_memory_arbiter.sv
// Two-master data memory arbiter: IDLE -> ACCESS -> RESPOND, one transaction in flight.
// Define RV_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m0 has fixed priority.
module example_data_memory_arbiter
  import rv_arbiter::*;
#(
  parameter logic INIT_LAST_GRANT = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write,
  output logic        m0_rsp_valid,
  input  logic        m0_rsp_ready,
  output logic [31:0] m0_rsp_data,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write,
  output logic        m1_rsp_valid,
  input  logic        m1_rsp_ready,
  output logic [31:0] m1_rsp_data,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic [31:0] bus_read_data
);

  arb_state_t state_q, state_d;

  logic [MASTER_COUNT-1:0] req_valid;
  logic grant_valid, grant_id, last_grant, accept;

  logic [31:0] addr_q, wdata_q, rsp_data_q;
  logic [3:0]  be_q;
  logic        write_q, id_q;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign accept    = (state_q == ARB_IDLE) && grant_valid;

  example_arb_picker u_picker (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef RV_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= INIT_LAST_GRANT;
    end else if (accept) begin
      last_grant_q <= grant_id;
    end
  end

  assign last_grant = last_grant_q;
`else
  // Pretending m1 was last granted makes the picker resolve every tie to m0.
  logic unused_init_last_grant;
  assign unused_init_last_grant = INIT_LAST_GRANT;
  assign last_grant = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= grant_id ? m1_addr        : m0_addr;
        wdata_q <= grant_id ? m1_wdata       : m0_wdata;
        be_q    <= grant_id ? m1_byte_enable : m0_byte_enable;
        write_q <= grant_id ? m1_write       : m0_write;
        id_q    <= grant_id;
      end
      if (state_q == ARB_ACCESS) begin
        rsp_data_q <= write_q ? 32'h0 : bus_read_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (grant_valid) state_d = ARB_ACCESS;
      ARB_ACCESS:  state_d = ARB_RESPOND;
      ARB_RESPOND: if (id_q ? m1_rsp_ready : m0_rsp_ready) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m0_req_ready     = 1'b0;
    m1_req_ready     = 1'b0;
    m0_rsp_valid     = 1'b0;
    m1_rsp_valid     = 1'b0;
    m0_rsp_data      = '0;
    m1_rsp_data      = '0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_byte_enable  = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        m0_req_ready = grant_valid && !grant_id;
        m1_req_ready = grant_valid && grant_id;
      end
      ARB_ACCESS: begin
        bus_address      = addr_q;
        bus_write_data   = wdata_q;
        bus_byte_enable  = be_q;
        bus_write_enable = write_q;
        bus_read_enable  = !write_q;
      end
      ARB_RESPOND: begin
        if (id_q) begin
          m1_rsp_valid = 1'b1;
          m1_rsp_data  = rsp_data_q;
        end else begin
          m0_rsp_valid = 1'b1;
          m0_rsp_data  = rsp_data_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_example_data_memory_arbiter.sv
// Directed scoreboard bench for example_data_memory_arbiter (either arbitration policy).
module tb_example_data_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        m0_req_valid, m0_req_ready, m0_write, m0_rsp_valid, m0_rsp_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rsp_data;
  logic [3:0]  m0_byte_enable;
  logic        m1_req_valid, m1_req_ready, m1_write, m1_rsp_valid, m1_rsp_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rsp_data;
  logic [3:0]  m1_byte_enable;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable, bus_write_enable;
  logic [31:0] rd_value;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   who;
  int   exp_order[4];

  assign bus_read_data = rd_value;

  always #5 clock = ~clock;

  example_data_memory_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .m0_req_valid     (m0_req_valid),
    .m0_req_ready     (m0_req_ready),
    .m0_addr          (m0_addr),
    .m0_wdata         (m0_wdata),
    .m0_byte_enable   (m0_byte_enable),
    .m0_write         (m0_write),
    .m0_rsp_valid     (m0_rsp_valid),
    .m0_rsp_ready     (m0_rsp_ready),
    .m0_rsp_data      (m0_rsp_data),
    .m1_req_valid     (m1_req_valid),
    .m1_req_ready     (m1_req_ready),
    .m1_addr          (m1_addr),
    .m1_wdata         (m1_wdata),
    .m1_byte_enable   (m1_byte_enable),
    .m1_write         (m1_write),
    .m1_rsp_valid     (m1_rsp_valid),
    .m1_rsp_ready     (m1_rsp_ready),
    .m1_rsp_data      (m1_rsp_data),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m0_req_ready"}, m0_req_ready, 0);
    check({tag, "_m1_req_ready"}, m1_req_ready, 0);
    check({tag, "_m0_rsp_valid"}, m0_rsp_valid, 0);
    check({tag, "_m1_rsp_valid"}, m1_rsp_valid, 0);
    check({tag, "_m0_rsp_data"}, m0_rsp_data, 0);
    check({tag, "_bus_re"}, bus_read_enable, 0);
    check({tag, "_bus_we"}, bus_write_enable, 0);
    check({tag, "_bus_addr"}, bus_address, 0);
    check({tag, "_bus_be"}, {28'h0, bus_byte_enable}, 0);
  endtask

  task automatic wait_accept(output int id);
    bit seen = 0;
    id = -1;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (m0_req_ready || m1_req_ready) begin
        seen = 1;
        id   = m1_req_ready ? 1 : 0;
        check("req_ready_onehot", m0_req_ready & m1_req_ready, 0);
      end else begin
        tick();
      end
    end
    if (!seen) check("accept_timeout", 1, 0);
  endtask

  // Pops the scoreboard on the first cycle any response is visible.
  task automatic collect(input int bound);
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < bound && !seen; i++) begin
      if (m0_rsp_valid || m1_rsp_valid) begin
        seen = 1;
        check("rsp_valid_onehot", m0_rsp_valid & m1_rsp_valid, 0);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", m1_rsp_valid, e.id);
          check("rsp_data", m1_rsp_valid ? m1_rsp_data : m0_rsp_data, e.data);
        end
      end else begin
        tick();
      end
    end
    if (!seen) check("rsp_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RV_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset_n = 1'b0;
    {m0_req_valid, m0_write, m1_req_valid, m1_write} = '0;
    m0_rsp_ready = 1'b1;
    m1_rsp_ready = 1'b1;
    {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
    m0_byte_enable = 4'hf;
    m1_byte_enable = 4'hf;
    rd_value = 32'h0;
    tick();
    check_outputs_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // m0 read: ready at cycle 0, bus read at cycle 1, response at cycle 2
    m0_req_valid = 1'b1;
    m0_addr = 32'h8000_0010;
    rd_value = 32'hDEAD_BEEF;
    #1;
    check("rd_c0_m0_ready", m0_req_ready, 1);
    check("rd_c0_m1_ready", m1_req_ready, 0);
    check("rd_c0_bus_re", bus_read_enable, 0);
    sb.push_back('{id: 1'b0, data: 32'hDEAD_BEEF});
    tick();
    m0_req_valid = 1'b0;
    check("rd_c1_bus_re", bus_read_enable, 1);
    check("rd_c1_bus_we", bus_write_enable, 0);
    check("rd_c1_bus_addr", bus_address, 32'h8000_0010);
    check("rd_c1_m0_ready", m0_req_ready, 0);
    check("rd_c1_rsp_valid", m0_rsp_valid, 0);
    tick();
    check("rd_c2_bus_re", bus_read_enable, 0);
    check("rd_c2_bus_addr", bus_address, 0);
    check("rd_c2_rsp_valid", m0_rsp_valid, 1);
    collect(1);
    tick();
    check("rd_c3_rsp_valid", m0_rsp_valid, 0);

    // m1 write with two byte lanes
    m1_req_valid = 1'b1;
    m1_addr = 32'h8000_0004;
    m1_wdata = 32'h1234_5678;
    m1_byte_enable = 4'h3;
    m1_write = 1'b1;
    rd_value = 32'hFFFF_FFFF;
    #1;
    check("wr_c0_m1_ready", m1_req_ready, 1);
    check("wr_c0_bus_we", bus_write_enable, 0);
    sb.push_back('{id: 1'b1, data: 32'h0});
    tick();
    m1_req_valid = 1'b0;
    check("wr_c1_bus_we", bus_write_enable, 1);
    check("wr_c1_bus_re", bus_read_enable, 0);
    check("wr_c1_bus_be", {28'h0, bus_byte_enable}, 32'h3);
    check("wr_c1_bus_wdata", bus_write_data, 32'h1234_5678);
    check("wr_c1_bus_addr", bus_address, 32'h8000_0004);
    tick();
    check("wr_c2_bus_we", bus_write_enable, 0);
    check("wr_c2_bus_be", {28'h0, bus_byte_enable}, 0);
    collect(1);
    tick();

    // Both masters request back to back for four transactions
    m1_write = 1'b0;
    m0_addr = 32'h8000_0100;
    m1_addr = 32'h8000_0200;
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      rd_value = 32'h1000_0000 + k;
      wait_accept(who);
      check("tie_grant_order", who, exp_order[k]);
      sb.push_back('{id: exp_order[k][0], data: 32'h1000_0000 + k});
      tick();
      collect(3);
      if (k == 3) begin
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
      end
      tick();
    end

    // m0 response stalled for five cycles while m1 waits
    m0_req_valid = 1'b1;
    m0_addr = 32'h8000_0300;
    m0_rsp_ready = 1'b0;
    rd_value = 32'hCAFE_F00D;
    #1;
    wait_accept(who);
    check("stall_first_grant", who, 0);
    sb.push_back('{id: 1'b0, data: 32'hCAFE_F00D});
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b1;
    m1_addr = 32'h8000_0400;
    #1;
    check("stall_access_m1_ready", m1_req_ready, 0);
    tick();
    rd_value = 32'h0BAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("stall_m0_rsp_valid", m0_rsp_valid, 1);
      check("stall_m0_rsp_data", m0_rsp_data, 32'hCAFE_F00D);
      check("stall_m1_req_ready", m1_req_ready, 0);
      check("stall_m1_rsp_valid", m1_rsp_valid, 0);
      tick();
    end
    m0_rsp_ready = 1'b1;
    #1;
    check("stall_release_m1_ready", m1_req_ready, 0);
    collect(1);
    tick();
    check("stall_after_m1_ready", m1_req_ready, 1);
    sb.push_back('{id: 1'b1, data: 32'h0BAD_BEEF});
    tick();
    m1_req_valid = 1'b0;
    tick();
    collect(1);
    tick();

    // A request withdrawn before any edge must not reach the bus
    m0_req_valid = 1'b1;
    #1;
    m0_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("withdraw_bus_re", bus_read_enable, 0);
      check("withdraw_bus_we", bus_write_enable, 0);
      check("withdraw_rsp_valid", m0_rsp_valid, 0);
    end

    // Reset during ACCESS abandons the transaction
    m0_req_valid = 1'b1;
    m0_addr = 32'h8000_0500;
    rd_value = 32'h7777_7777;
    #1;
    wait_accept(who);
    check("rst_pre_grant", who, 0);
    tick();
    m0_req_valid = 1'b0;
    check("rst_pre_bus_re", bus_read_enable, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_m0_rsp_valid", m0_rsp_valid, 0);
      check("post_rst_m1_rsp_valid", m1_rsp_valid, 0);
      check("post_rst_bus_re", bus_read_enable, 0);
    end
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    rd_value = 32'h55AA_55AA;
    #1;
    wait_accept(who);
    check("post_rst_tie_grant", who, 0);
    sb.push_back('{id: 1'b0, data: 32'h55AA_55AA});
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    tick();
    collect(1);
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/example_data_memory_arbiter.md
EXAMPLE_DATA_MEMORY_ARBITER -- requirements
Module: example_data_memory_arbiter

Interface
REQ-001 SHALL have parameter INIT_LAST_GRANT, default 1: requester treated as last-granted after reset, so m0 wins the first tie.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mN_req_valid (N=0,1), input, 1: requester N presents a request.
REQ-005 SHALL have port mN_req_ready, output, 1: request accepted this cycle.
REQ-006 SHALL have port mN_addr, input, 32: byte address.
REQ-007 SHALL have port mN_wdata, input, 32: write data.
REQ-008 SHALL have port mN_byte_enable, input, 4: byte lanes.
REQ-009 SHALL have port mN_write, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port mN_rsp_valid, output, 1: response available.
REQ-011 SHALL have port mN_rsp_ready, input, 1: requester takes the response.
REQ-012 SHALL have port mN_rsp_data, output, 32: read data (0 for writes).
REQ-013 SHALL have ports bus_address (32), bus_write_data (32), bus_byte_enable (4), bus_read_enable (1) and bus_write_enable (1), all outputs, driving the data memory bus.
REQ-014 SHALL have port bus_read_data, input, 32: combinational read data from the data memory bus.

Function
REQ-015 SHALL implement FSM ARB_IDLE -> ARB_ACCESS -> ARB_RESPOND -> ARB_IDLE.
REQ-016 In ARB_IDLE with any mN_req_valid, SHALL pick a winner, assert its mN_req_ready for exactly that cycle, latch its addr/wdata/byte_enable/write and id, and go to ARB_ACCESS.
REQ-017 In ARB_IDLE with no request, SHALL stay in ARB_IDLE with every req_ready low.
REQ-018 In ARB_ACCESS, SHALL drive bus_* from the latched request for exactly one cycle: bus_write_enable = latched write; bus_read_enable = !latched write.
REQ-019 In ARB_ACCESS, SHALL register bus_read_data into the response register on the same edge (0 for writes), then go to ARB_RESPOND.
REQ-020 In every state other than ARB_ACCESS, SHALL hold bus_read_enable and bus_write_enable at 0 and bus_address/bus_write_data/bus_byte_enable at 0.
REQ-021 In ARB_RESPOND, SHALL assert rsp_valid only to the latched winner, with rsp_data stable, until rsp_ready is high; it SHALL then return to ARB_IDLE on the next edge.
REQ-022 Latency SHALL be 2 cycles from the accept edge to the first rsp_valid, and at most 1 transaction per 3 cycles.
REQ-023 rsp_ready held low SHALL stall indefinitely; new requests SHALL NOT be accepted while stalled.
REQ-024 With simultaneous requests, SHALL grant per the arbitration policy (see Configuration) and update last-grant on each accept.
REQ-025 A requester dropping req_valid before accept SHALL cause no bus access.
REQ-026 A requester's req_valid SHALL have no effect outside ARB_IDLE.

Reset
REQ-027 reset_n low SHALL immediately force ARB_IDLE, all outputs 0, last-grant = INIT_LAST_GRANT and the response register = 0, abandoning any in-flight transaction with no response.

Configuration
REQ-028 With macro RV_ARB_ROUND_ROBIN_EN defined, SHALL use round-robin: on a tie, the requester not last granted wins.
REQ-029 Without RV_ARB_ROUND_ROBIN_EN, SHALL use fixed priority: m0 always wins a tie, and the last-grant register SHALL be absent.

Structure
REQ-030 SHALL place the state enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RESPOND} and MASTER_COUNT = 2 in a shared package rv_arbiter.
REQ-031 SHALL use one sub-module, example_arb_picker: combinational winner select from req_valid[1:0] and last-grant.

Verification
REQ-032 Scenario: m0 read addr 0x80000010, bus_read_data = 0xDEADBEEF -> req_ready at cycle 0, bus_read_enable only at cycle 1, m0_rsp_valid with 0xDEADBEEF at cycle 2.
REQ-033 Scenario: m1 write addr 0x80000004, data 0x12345678, be 0x3 -> exactly one cycle with bus_write_enable = 1 and bus_byte_enable = 0x3; m1_rsp_data = 0.
REQ-034 Scenario: both request continuously for 4 transactions -> grants m0,m1,m0,m1 with RV_ARB_ROUND_ROBIN_EN; m0,m0,m0,m0 without it.
REQ-035 Scenario: m0_rsp_ready held low for 5 cycles while m1 requests -> m0_rsp_valid stays high with stable data; m1_req_ready stays 0 until cycle after m0_rsp_ready.
REQ-036 Scenario: reset_n pulsed low during ARB_ACCESS -> all outputs 0 asynchronously, no rsp_valid, next tie grants m0.
